// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants and decoder state type for the PS/2 decode path.
//   SC_EXT / SC_BRK    : extended and break prefix bytes
//   SC_LSHIFT/SC_RSHIFT: left/right shift make codes (used when PS2_SHIFT_EN is defined)
//   dec_state_t        : byte handshake FSM states
package ps2_pkg;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   typedef enum logic [1:0] {IDLE, ACK, DECODE} dec_state_t;
endpackage

// File: rtl/ps2_ascii_rom.sv
// ps2_ascii_rom: combinational set-2 scan code to ASCII lookup.
//   code_i  [7:0] : scan code (non-extended)
//   shift_i       : shift held; letters go uppercase, digits go to US shifted symbols
//   ascii_o [7:0] : ASCII, 0 for unmapped codes
module ps2_ascii_rom (
   input  logic [7:0] code_i,
   input  logic       shift_i,
   output logic [7:0] ascii_o
);
   logic [7:0] base, sym;
   always_comb begin
      case (code_i)
         8'h1C: base = 8'h61;
         8'h32: base = 8'h62;
         8'h21: base = 8'h63;
         8'h23: base = 8'h64;
         8'h24: base = 8'h65;
         8'h2B: base = 8'h66;
         8'h34: base = 8'h67;
         8'h33: base = 8'h68;
         8'h43: base = 8'h69;
         8'h3B: base = 8'h6A;
         8'h42: base = 8'h6B;
         8'h4B: base = 8'h6C;
         8'h3A: base = 8'h6D;
         8'h31: base = 8'h6E;
         8'h44: base = 8'h6F;
         8'h4D: base = 8'h70;
         8'h15: base = 8'h71;
         8'h2D: base = 8'h72;
         8'h1B: base = 8'h73;
         8'h2C: base = 8'h74;
         8'h3C: base = 8'h75;
         8'h2A: base = 8'h76;
         8'h1D: base = 8'h77;
         8'h22: base = 8'h78;
         8'h35: base = 8'h79;
         8'h1A: base = 8'h7A;
         8'h45: base = 8'h30;
         8'h16: base = 8'h31;
         8'h1E: base = 8'h32;
         8'h26: base = 8'h33;
         8'h25: base = 8'h34;
         8'h2E: base = 8'h35;
         8'h36: base = 8'h36;
         8'h3D: base = 8'h37;
         8'h3E: base = 8'h38;
         8'h46: base = 8'h39;
         8'h29: base = 8'h20;
         8'h5A: base = 8'h0D;
         default: base = 8'h00;
      endcase
   end
   // Shifted form derived from the unshifted character so the code table stays single.
   always_comb begin
      case (base)
         8'h30: sym = 8'h29;
         8'h31: sym = 8'h21;
         8'h32: sym = 8'h40;
         8'h33: sym = 8'h23;
         8'h34: sym = 8'h24;
         8'h35: sym = 8'h25;
         8'h36: sym = 8'h5E;
         8'h37: sym = 8'h26;
         8'h38: sym = 8'h2A;
         8'h39: sym = 8'h28;
         default: sym = (base >= 8'h61 && base <= 8'h7A) ? base - 8'h20 : base;
      endcase
   end
   assign ascii_o = shift_i ? sym : base;
endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: pops PS/2 scan bytes from the keyboard FIFO and tracks the held key.
//   clk, clrn (sync active-low reset)
//   data[7:0], ready : FIFO head byte and non-empty flag
//   nextdata_n       : active-low pop request, low only in ACK
//   key_code, key_ext, ascii : last counted key press
//   key_valid        : a key is held
//   key_event        : one-cycle pulse per counted press
//   press_count      : wrapping count of presses
// Optional: define PS2_SHIFT_EN to treat 12/59 as shift modifiers for ASCII.
module ps2_scan_decoder (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] data,
   input  logic       ready,
   output logic       nextdata_n,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic [7:0] ascii,
   output logic       key_valid,
   output logic       key_event,
   output logic [7:0] press_count
);
   import ps2_pkg::*;
   dec_state_t state_q, state_d;
   logic [7:0] byte_q, byte_d, key_code_q, key_code_d, ascii_q, ascii_d, cnt_q, cnt_d, rom_ascii;
   logic       ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d, key_ext_q, key_ext_d;
   logic       valid_q, valid_d, event_q, event_d, shift_q, shift_d, hit;
   ps2_ascii_rom u_rom (
      .code_i  (byte_q),
      .shift_i (shift_q),
      .ascii_o (rom_ascii)
   );
   always_ff @(posedge clk) begin
      if (!clrn) state_q <= IDLE;
      else       state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (ready ? ACK : IDLE) : (state_q == ACK) ? DECODE : IDLE;
   end
   always_comb begin
      nextdata_n = (state_q != ACK);
   end
   // Same key means same code and same extended-ness.
   assign hit = (byte_q == key_code_q) && (ext_pend_q == key_ext_q);
   always_comb begin
      byte_d     = (state_q == IDLE && ready) ? data : byte_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      key_code_d = key_code_q;
      key_ext_d  = key_ext_q;
      ascii_d    = ascii_q;
      valid_d    = valid_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      event_d    = 1'b0;
      if (state_q == DECODE) begin
         if (byte_q == SC_EXT) ext_pend_d = 1'b1;
         else if (byte_q == SC_BRK) brk_pend_d = 1'b1;
`ifdef PS2_SHIFT_EN
         else if (!ext_pend_q && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT)) begin
            shift_d    = !brk_pend_q;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end
`endif
         else if (brk_pend_q) begin
            valid_d    = hit ? 1'b0 : valid_q;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
         end else begin
            ext_pend_d = 1'b0;
            // A repeat of the held key is typematic and is not counted.
            if (!(valid_q && hit)) begin
               key_code_d = byte_q;
               key_ext_d  = ext_pend_q;
               ascii_d    = ext_pend_q ? 8'h00 : rom_ascii;
               valid_d    = 1'b1;
               cnt_d      = cnt_q + 8'd1;
               event_d    = 1'b1;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!clrn) begin
         byte_q     <= 8'h00;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         key_code_q <= 8'h00;
         key_ext_q  <= 1'b0;
         ascii_q    <= 8'h00;
         valid_q    <= 1'b0;
         cnt_q      <= 8'h00;
         shift_q    <= 1'b0;
         event_q    <= 1'b0;
      end else begin
         byte_q     <= byte_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         key_code_q <= key_code_d;
         key_ext_q  <= key_ext_d;
         ascii_q    <= ascii_d;
         valid_q    <= valid_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         event_q    <= event_d;
      end
   end
   assign key_code    = key_code_q;
   assign key_ext     = key_ext_q;
   assign ascii       = ascii_q;
   assign key_valid   = valid_q;
   assign key_event   = event_q;
   assign press_count = cnt_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: FIFO model + event scoreboard + vector table for ps2_scan_decoder.
module tb_ps2_scan_decoder;
   logic       clk = 1'b0, clrn = 1'b0, ready = 1'b0;
   logic [7:0] data = 8'h00;
   logic       nextdata_n, key_ext, key_valid, key_event;
   logic [7:0] key_code, ascii, press_count;

   always #5 clk = ~clk;

   ps2_scan_decoder dut (
      .clk(clk), .clrn(clrn), .data(data), .ready(ready), .nextdata_n(nextdata_n),
      .key_code(key_code), .key_ext(key_ext), .ascii(ascii), .key_valid(key_valid),
      .key_event(key_event), .press_count(press_count)
   );

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic [7:0] asc;
      logic [7:0] cnt;
   } ev_t;

   typedef struct packed {
      logic [2:0]  n;
      logic [31:0] b;
      logic [7:0]  code;
      logic        ext;
      logic [7:0]  asc;
      logic        valid;
      logic [7:0]  cnt;
      logic        ev;
   } vec_t;

   logic [7:0] fifo[$];
   ev_t        exp_q[$];
   ev_t        obs_q[$];
   int         n_chk = 0, errors = 0, pushed = 0, pops = 0, viol = 0;
   bit         nd_prev = 1'b0, ev_prev = 1'b0;

   // FIFO model (pops at the end of ACK) and output observer.
   always @(negedge clk) begin
      if (key_event) obs_q.push_back(ev_t'({key_code, key_ext, ascii, press_count}));
      if (key_event && ev_prev) viol++;
      ev_prev = key_event;
      if (!nextdata_n) begin
         if (nd_prev || fifo.size() == 0) viol++;
         if (fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
         end
      end
      nd_prev = !nextdata_n;
      ready = fifo.size() != 0;
      data = ready ? fifo[0] : 8'h00;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1);
   end

   task automatic chk(string nm, int act, int req);
      n_chk++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic push(logic [7:0] b);
      fifo.push_back(b);
      pushed++;
   endtask

   task automatic expect_ev(logic [7:0] c, logic e, logic [7:0] a, logic [7:0] n);
      exp_q.push_back(ev_t'({c, e, a, n}));
   endtask

   task automatic drain(string tag);
      int t = 0;
      while (fifo.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #2;
      if (t >= 5000) begin
         n_chk++;
         errors++;
         $display("FAIL %s.drain: %0d bytes left after %0d cycles, required 0", tag, fifo.size(), t);
      end
   endtask

   task automatic sb_check(string tag);
      ev_t o, e;
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front();
         n_chk++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s.event: got code=%h ext=%b ascii=%h cnt=%0d, required no event", tag, o.code, o.ext, o.asc, o.cnt);
         end else begin
            e = exp_q.pop_front();
            if (o != e) begin
               errors++;
               $display("FAIL %s.event: got code=%h ext=%b ascii=%h cnt=%0d, required code=%h ext=%b ascii=%h cnt=%0d",
                        tag, o.code, o.ext, o.asc, o.cnt, e.code, e.ext, e.asc, e.cnt);
            end
         end
      end
      chk({tag, ".missing_events"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_out(string tag, logic [7:0] c, logic e, logic [7:0] a, logic v, logic [7:0] n);
      chk({tag, ".key_code"}, key_code, c);
      chk({tag, ".key_ext"}, key_ext, e);
      chk({tag, ".ascii"}, ascii, a);
      chk({tag, ".key_valid"}, key_valid, v);
      chk({tag, ".press_count"}, press_count, n);
   endtask

   function automatic vec_t mk(int n, logic [31:0] b, logic [7:0] c, logic e, logic [7:0] a, logic v, logic [7:0] cnt, logic ev);
      vec_t r;
      r.n = n[2:0]; r.b = b; r.code = c; r.ext = e; r.asc = a; r.valid = v; r.cnt = cnt; r.ev = ev;
      return r;
   endfunction

   initial begin
      vec_t tbl[16];
      int   t;
      tbl[0]  = mk(1, 32'h1C000000, 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1, 1'b1);
      tbl[1]  = mk(3, 32'h1C1C1C00, 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1, 1'b0);
      tbl[2]  = mk(2, 32'hF01C0000, 8'h1C, 1'b0, 8'h61, 1'b0, 8'd1, 1'b0);
      tbl[3]  = mk(2, 32'hE0750000, 8'h75, 1'b1, 8'h00, 1'b1, 8'd2, 1'b1);
      tbl[4]  = mk(3, 32'hE0F07500, 8'h75, 1'b1, 8'h00, 1'b0, 8'd2, 1'b0);
      tbl[5]  = mk(1, 32'h16000000, 8'h16, 1'b0, 8'h31, 1'b1, 8'd3, 1'b1);
      tbl[6]  = mk(1, 32'h29000000, 8'h29, 1'b0, 8'h20, 1'b1, 8'd4, 1'b1);
      tbl[7]  = mk(2, 32'hF0160000, 8'h29, 1'b0, 8'h20, 1'b1, 8'd4, 1'b0);
      tbl[8]  = mk(1, 32'h5A000000, 8'h5A, 1'b0, 8'h0D, 1'b1, 8'd5, 1'b1);
      tbl[9]  = mk(2, 32'hE05A0000, 8'h5A, 1'b1, 8'h00, 1'b1, 8'd6, 1'b1);
      tbl[10] = mk(2, 32'hF05A0000, 8'h5A, 1'b1, 8'h00, 1'b1, 8'd6, 1'b0);
      tbl[11] = mk(3, 32'hE0F05A00, 8'h5A, 1'b1, 8'h00, 1'b0, 8'd6, 1'b0);
      tbl[12] = mk(1, 32'h4D000000, 8'h4D, 1'b0, 8'h70, 1'b1, 8'd7, 1'b1);
      tbl[13] = mk(1, 32'h45000000, 8'h45, 1'b0, 8'h30, 1'b1, 8'd8, 1'b1);
      tbl[14] = mk(2, 32'hF0450000, 8'h45, 1'b0, 8'h30, 1'b0, 8'd8, 1'b0);
      tbl[15] = mk(1, 32'h0E000000, 8'h0E, 1'b0, 8'h00, 1'b1, 8'd9, 1'b1);

      repeat (3) @(posedge clk);
      #2;
      chk("reset.nextdata_n", nextdata_n, 1);
      chk("reset.key_event", key_event, 0);
      check_out("reset", 8'h00, 1'b0, 8'h00, 1'b0, 8'd0);
      clrn = 1'b1;

      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < int'(tbl[i].n); k++) push(tbl[i].b[31 - 8 * k -: 8]);
         if (tbl[i].ev) expect_ev(tbl[i].code, tbl[i].ext, tbl[i].asc, tbl[i].cnt);
         drain($sformatf("vec%0d", i));
         sb_check($sformatf("vec%0d", i));
         check_out($sformatf("vec%0d", i), tbl[i].code, tbl[i].ext, tbl[i].asc, tbl[i].valid, tbl[i].cnt);
      end

`ifdef PS2_SHIFT_EN
      push(8'h12);
      drain("shift_make");
      sb_check("shift_make");
      check_out("shift_make", 8'h0E, 1'b0, 8'h00, 1'b1, 8'd9);
      push(8'h1C);
      expect_ev(8'h1C, 1'b0, 8'h41, 8'd10);
      drain("shift_A");
      sb_check("shift_A");
      check_out("shift_A", 8'h1C, 1'b0, 8'h41, 1'b1, 8'd10);
      push(8'hF0); push(8'h12); push(8'hF0); push(8'h1C); push(8'h1C);
      expect_ev(8'h1C, 1'b0, 8'h61, 8'd11);
      drain("unshift_a");
      sb_check("unshift_a");
      check_out("unshift_a", 8'h1C, 1'b0, 8'h61, 1'b1, 8'd11);
      push(8'h59); push(8'h16);
      expect_ev(8'h16, 1'b0, 8'h21, 8'd12);
      drain("shift_bang");
      sb_check("shift_bang");
      check_out("shift_bang", 8'h16, 1'b0, 8'h21, 1'b1, 8'd12);
      push(8'hF0); push(8'h16); push(8'hF0); push(8'h59);
      drain("shift_rel");
      sb_check("shift_rel");
      check_out("shift_rel", 8'h16, 1'b0, 8'h21, 1'b0, 8'd12);
`else
      push(8'h12);
      expect_ev(8'h12, 1'b0, 8'h00, 8'd10);
      drain("lshift_key");
      sb_check("lshift_key");
      check_out("lshift_key", 8'h12, 1'b0, 8'h00, 1'b1, 8'd10);
      push(8'h59); push(8'h1C);
      expect_ev(8'h59, 1'b0, 8'h00, 8'd11);
      expect_ev(8'h1C, 1'b0, 8'h61, 8'd12);
      drain("no_shift_a");
      sb_check("no_shift_a");
      check_out("no_shift_a", 8'h1C, 1'b0, 8'h61, 1'b1, 8'd12);
`endif

      // Reset while the first of two queued bytes is in ACK.
      push(8'h24); push(8'h1C);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (nextdata_n && t < 50);
      chk("rst_ack.reached_ack", nextdata_n, 0);
      clrn = 1'b0;
      @(posedge clk);
      #2;
      chk("rst_ack.nextdata_n", nextdata_n, 1);
      chk("rst_ack.key_event", key_event, 0);
      check_out("rst_ack", 8'h00, 1'b0, 8'h00, 1'b0, 8'd0);
      @(posedge clk);
      #2;
      chk("rst_hold.nextdata_n", nextdata_n, 1);
      chk("rst_hold.fifo_kept", fifo.size(), 1);
      clrn = 1'b1;
      expect_ev(8'h1C, 1'b0, 8'h61, 8'd1);
      drain("rst_resume");
      sb_check("rst_resume");
      check_out("rst_resume", 8'h1C, 1'b0, 8'h61, 1'b1, 8'd1);

      // 255 more press/release pairs: 256 presses since reset wrap the count to 0.
      push(8'hF0); push(8'h1C);
      for (int i = 1; i < 256; i++) begin
         push(8'h1C); push(8'hF0); push(8'h1C);
         expect_ev(8'h1C, 1'b0, 8'h61, 8'((i + 1) % 256));
      end
      drain("wrap");
      sb_check("wrap");
      check_out("wrap", 8'h1C, 1'b0, 8'h61, 1'b0, 8'd0);

      chk("pops_per_byte", pops, pushed);
      chk("protocol_violations", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errors);
      $finish;
   end
endmodule
